bus_mem: RTL

Memory-side responder on the shared CPU bus, which is driven by the `cpu` initiator (`addr_bus`, bidirectional `data_bus`, `wr_en`). It serves combinational reads and posted single-cycle writes. After reset it runs a clear sweep that fills the array with a known value. It also has a load port so the testbench can preload a program while the bus is idle.

---
 rtl/bus_mem_pkg.sv | 13 +
 rtl/bus_mem_array.sv | 25 ++
 rtl/bus_mem.sv | 92 +++++++++
 3 files changed

// File: rtl/bus_mem_pkg.sv
// Shared bus memory types: FSM encoding and default
// bus geometry common to the memory and the CPU.
package bus_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  localparam int MEM_WIDTH_DEF = 8;
  localparam int WORD_SIZE_DEF = 8;

endpackage

// File: rtl/bus_mem_array.sv
// Storage array: one synchronous write port and one
// asynchronous read port.
module bus_mem_array #(
  parameter int W  = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  localparam int DEPTH = 2 ** AW;

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bus_mem.sv
// Bus-side memory responder: clear sweep after reset,
// combinational reads, posted writes and a load port.
module bus_mem
  import bus_mem_pkg::*;
#(
  parameter int MEM_WIDTH = MEM_WIDTH_DEF,
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter logic [MEM_WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] addr_bus,
  inout  wire  [MEM_WIDTH-1:0] data_bus,
  input  logic                 wr_en,
  input  logic                 load_valid,
  input  logic [WORD_SIZE-1:0] load_addr,
  input  logic [MEM_WIDTH-1:0] load_data,
  output logic                 load_ready,
  output logic                 init_done,
  output logic                 err
);

  localparam logic [WORD_SIZE-1:0] LAST = '1;

  state_e               state_q;
  logic [WORD_SIZE-1:0] clr_cnt_q;
  logic                 init_done_q;
  logic                 err_q;

  logic                 we;
  logic [WORD_SIZE-1:0] waddr;
  logic [MEM_WIDTH-1:0] wdata;
  logic [MEM_WIDTH-1:0] rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + WORD_SIZE'(1);
          if (wr_en) err_q <= 1'b1;
          if (clr_cnt_q == LAST) begin
            state_q     <= IDLE;
            init_done_q <= 1'b1;
          end
        end
        IDLE: ;
        default: state_q <= CLEAR;
      endcase
    end
  end

  // Single write port: sweep beats bus write beats load.
  always_comb begin
    we    = 1'b0;
    waddr = load_addr;
    wdata = load_data;
    if (state_q == CLEAR) begin
      we    = 1'b1;
      waddr = clr_cnt_q;
      wdata = INIT_VAL;
    end else if (wr_en) begin
      we    = 1'b1;
      waddr = addr_bus;
      wdata = data_bus;
    end else if (load_valid) begin
      we    = 1'b1;
    end
  end

  bus_mem_array #(
    .W  (MEM_WIDTH),
    .AW (WORD_SIZE)
  ) u_array (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (addr_bus),
    .rdata_o (rdata)
  );

  assign load_ready = (state_q == IDLE) && !wr_en;
  assign data_bus   = load_ready ? rdata : 'z;
  assign init_done  = init_done_q;
  assign err        = err_q;

endmodule
